// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver family.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line front end: 2-flop synchroniser, per-bit sample counter and
// 3-sample majority vote around the bit centre.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  input  logic run,
  output logic rx_s,
  output logic fall,
  output logic bit_val,
  output logic bit_strobe,
  output logic bit_end
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_LO  = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE/2);
  localparam logic [SW-1:0] S_HI  = SW'(OVERSAMPLE/2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

  logic          rx_meta_q, rx_meta_d;
  logic          rx_s_q, rx_s_d;
  logic          rx_prev_q, rx_prev_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic          smp_lo_q, smp_lo_d;
  logic          smp_mid_q, smp_mid_d;

  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    rx_prev_d = rx_s_q;
    // counter parks at 0 whenever the receiver is not inside a frame
    scnt_d    = '0;
    if (run) scnt_d = (scnt_q == S_END) ? '0 : scnt_q + 1'b1;
    smp_lo_d  = (run && scnt_q == S_LO)  ? rx_s_q : smp_lo_q;
    smp_mid_d = (run && scnt_q == S_MID) ? rx_s_q : smp_mid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      scnt_q    <= '0;
      smp_lo_q  <= 1'b0;
      smp_mid_q <= 1'b0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      rx_prev_q <= rx_prev_d;
      scnt_q    <= scnt_d;
      smp_lo_q  <= smp_lo_d;
      smp_mid_q <= smp_mid_d;
    end
  end

  assign rx_s       = rx_s_q;
  assign fall       = rx_prev_q & ~rx_s_q;
  assign bit_strobe = run && (scnt_q == S_HI);
  assign bit_end    = run && (scnt_q == S_END);
  assign bit_val    = maj3(smp_lo_q, smp_mid_q, rx_s_q);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver (data width, oversample, parity, stop bits).
// Define UART_RX_BREAK_DET_EN to add break detection (brk port, BRK_WAIT).
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 2,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dataout,
  output logic                 rdsig,
  output logic                 dataerror,
  output logic                 frameerror,
  output logic                 busy
`ifdef UART_RX_BREAK_DET_EN
  ,output logic                brk
`endif
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (OVERSAMPLE < 8 || OVERSAMPLE > 64 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("uart_rx_param: OVERSAMPLE must be even, 8..64");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_rx_param: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  logic rx_s, fall, bit_val, bit_strobe, bit_end, run;

  rx_state_t            state_q, state_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] dataout_q, dataout_d;
  logic                 rdsig_q, rdsig_d;
  logic                 dataerror_q, dataerror_d;
  logic                 frameerror_q, frameerror_d;
  logic                 busy_q, busy_d;
`ifdef UART_RX_BREAK_DET_EN
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] HI_LAST = SW'(OVERSAMPLE - 1);
  logic          zero_q, zero_d;
  logic          brk_q, brk_d;
  logic [SW-1:0] hi_cnt_q, hi_cnt_d;
`else
  logic unused_rx_s;
  assign unused_rx_s = rx_s;
`endif

  assign run = (state_q == START) || (state_q == DATA) ||
               (state_q == PARITY) || (state_q == STOP);

  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .run        (run),
    .rx_s       (rx_s),
    .fall       (fall),
    .bit_val    (bit_val),
    .bit_strobe (bit_strobe),
    .bit_end    (bit_end)
  );

  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    stop_cnt_d   = stop_cnt_q;
    dataout_d    = dataout_q;
    rdsig_d      = 1'b0;
    dataerror_d  = dataerror_q;
    frameerror_d = frameerror_q;
    busy_d       = busy_q;
`ifdef UART_RX_BREAK_DET_EN
    zero_d   = zero_q;
    brk_d    = 1'b0;
    hi_cnt_d = hi_cnt_q;
`endif
    case (state_q)
      IDLE: if (fall) begin
        state_d    = START;
        busy_d     = 1'b1;
        bcnt_d     = '0;
        par_d      = (PARITY_MODE == PAR_ODD);
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        stop_cnt_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        zero_d     = 1'b1;
`endif
      end
      START: begin
        if (bit_strobe && bit_val) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        // LSB arrives first, so after DATA_BITS shifts it sits at bit 0
        if (bit_strobe) begin
          shreg_d = {bit_val, shreg_q[DATA_BITS-1:1]};
          par_d   = par_q ^ bit_val;
`ifdef UART_RX_BREAK_DET_EN
          zero_d  = zero_q & ~bit_val;
`endif
        end
        if (bit_end) begin
          if (bcnt_q == LAST_BIT) state_d = (PARITY_MODE == PAR_NONE) ? STOP : PARITY;
          else                    bcnt_d  = bcnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (bit_strobe) begin
          if (bit_val != par_q) perr_d = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
          zero_d = zero_q & ~bit_val;
`endif
        end
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_strobe && stop_cnt_q == LAST_STOP) begin
          state_d = IDLE;
          busy_d  = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
          if (zero_q && !bit_val) begin
            brk_d    = 1'b1;
            state_d  = BRK_WAIT;
            busy_d   = 1'b1;
            hi_cnt_d = '0;
          end else
`endif
          begin
            rdsig_d      = 1'b1;
            dataout_d    = shreg_q;
            dataerror_d  = perr_q;
            frameerror_d = ferr_q | ~bit_val;
          end
        end else begin
          if (bit_strobe) begin
            ferr_d = ferr_q | ~bit_val;
`ifdef UART_RX_BREAK_DET_EN
            zero_d = zero_q & ~bit_val;
`endif
          end
          if (bit_end) stop_cnt_d = 1'b1;
        end
      end
`ifdef UART_RX_BREAK_DET_EN
      BRK_WAIT: begin
        if (!rx_s)                     hi_cnt_d = '0;
        else if (hi_cnt_q == HI_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else                       hi_cnt_d = hi_cnt_q + 1'b1;
      end
`endif
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bcnt_q       <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      stop_cnt_q   <= 1'b0;
      dataout_q    <= '0;
      rdsig_q      <= 1'b0;
      dataerror_q  <= 1'b0;
      frameerror_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      zero_q       <= 1'b0;
      brk_q        <= 1'b0;
      hi_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      stop_cnt_q   <= stop_cnt_d;
      dataout_q    <= dataout_d;
      rdsig_q      <= rdsig_d;
      dataerror_q  <= dataerror_d;
      frameerror_q <= frameerror_d;
      busy_q       <= busy_d;
`ifdef UART_RX_BREAK_DET_EN
      zero_q       <= zero_d;
      brk_q        <= brk_d;
      hi_cnt_q     <= hi_cnt_d;
`endif
    end
  end

  assign dataout    = dataout_q;
  assign rdsig      = rdsig_q;
  assign dataerror  = dataerror_q;
  assign frameerror = frameerror_q;
  assign busy       = busy_q;
`ifdef UART_RX_BREAK_DET_EN
  assign brk        = brk_q;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: default instance plus a
// 7-bit / odd parity / 2-stop / 8x instance. Covers UART_RX_BREAK_DET_EN too.
module tb_uart_rx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n0, rst_n1, rx0, rx1;
  logic [7:0] dout0;
  logic [6:0] dout1;
  logic       rdsig0, derr0, ferr0, busy0, brk0;
  logic       rdsig1, derr1, ferr1, busy1, brk1;

  uart_rx_param dut0 (
    .clk(clk), .rst_n(rst_n0), .rx(rx0), .dataout(dout0), .rdsig(rdsig0),
    .dataerror(derr0), .frameerror(ferr0), .busy(busy0)
`ifdef UART_RX_BREAK_DET_EN
    , .brk(brk0)
`endif
  );

  uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(8), .PARITY_MODE(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst_n(rst_n1), .rx(rx1), .dataout(dout1), .rdsig(rdsig1),
    .dataerror(derr1), .frameerror(ferr1), .busy(busy1)
`ifdef UART_RX_BREAK_DET_EN
    , .brk(brk1)
`endif
  );

`ifndef UART_RX_BREAK_DET_EN
  assign brk0 = 1'b0;
  assign brk1 = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       brk;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // monitors: every rdsig/brk event pops one expectation
  always @(negedge clk) begin
    if (rdsig0 || brk0) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL ch0_unexpected_event: got rdsig=%0b brk=%0b expected none", rdsig0, brk0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("ch0_dataout",    32'(dout0), 32'(e.d));
        chk("ch0_dataerror",  32'(derr0), 32'(e.pe));
        chk("ch0_frameerror", 32'(ferr0), 32'(e.fe));
        chk("ch0_brk",        32'(brk0),  32'(e.brk));
        chk("ch0_rdsig",      32'(rdsig0), 32'(!e.brk));
      end
    end
  end

  always @(negedge clk) begin
    if (rdsig1 || brk1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL ch1_unexpected_event: got rdsig=%0b brk=%0b expected none", rdsig1, brk1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("ch1_dataout",    32'(dout1), 32'(e.d));
        chk("ch1_dataerror",  32'(derr1), 32'(e.pe));
        chk("ch1_frameerror", 32'(ferr1), 32'(e.fe));
        chk("ch1_brk",        32'(brk1),  32'(e.brk));
      end
    end
  end

  task automatic drive(input int ch, input logic v, input int n);
    if (ch == 0) rx0 = v; else rx1 = v;
    repeat (n) @(negedge clk);
  endtask

  // glitch >= 0 puts a 1-clk low pulse at the centre of that data bit
  task automatic send(input int ch, input int nb, input int os, input logic [8:0] d,
                      input int pm, input bit flip, input int nstop, input logic stopv,
                      input int glitch);
    logic p;
    p = 1'b0;
    for (int i = 0; i < nb; i++) p ^= d[i];
    if (pm == 1) p = ~p;
    if (flip)    p = ~p;
    drive(ch, 1'b0, os);
    for (int i = 0; i < nb; i++) begin
      if (i == glitch) begin
        drive(ch, d[i], os/2);
        drive(ch, 1'b0, 1);
        drive(ch, d[i], os/2 - 1);
      end else begin
        drive(ch, d[i], os);
      end
    end
    if (pm != 0) drive(ch, p, os);
    for (int s = 0; s < nstop; s++) drive(ch, stopv, os);
  endtask

  function automatic void push0(input logic [8:0] d, input logic pe, input logic fe, input logic b);
    q0.push_back('{d: d, pe: pe, fe: fe, brk: b});
  endfunction

  function automatic void push1(input logic [8:0] d, input logic pe, input logic fe);
    q1.push_back('{d: d, pe: pe, fe: fe, brk: 1'b0});
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rx0 = 1'b1; rx1 = 1'b1;
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dataout0",    32'(dout0),  32'h0);
    chk("rst_rdsig0",      32'(rdsig0), 32'h0);
    chk("rst_dataerror0",  32'(derr0),  32'h0);
    chk("rst_frameerror0", 32'(ferr0),  32'h0);
    chk("rst_busy0",       32'(busy0),  32'h0);
    chk("rst_busy1",       32'(busy1),  32'h0);
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    repeat (4) @(negedge clk);

    // good frame, correct even parity
    push0(9'h0A5, 1'b0, 1'b0, 1'b0);
    send(0, 8, 16, 9'h0A5, 2, 1'b0, 1, 1'b1, -1);
    drive(0, 1'b1, 32);

    // parity bit inverted
    push0(9'h0A5, 1'b1, 1'b0, 1'b0);
    send(0, 8, 16, 9'h0A5, 2, 1'b1, 1, 1'b1, -1);
    drive(0, 1'b1, 32);

    // stop bit low, then line held low: must not retrigger
    push0(9'h03C, 1'b0, 1'b1, 1'b0);
    send(0, 8, 16, 9'h03C, 2, 1'b0, 1, 1'b0, -1);
    drive(0, 1'b0, 200);
    chk("held_low_frameerror", 32'(ferr0), 32'h1);
    chk("held_low_dataout",    32'(dout0), 32'h3C);
    chk("held_low_busy",       32'(busy0), 32'h0);
    drive(0, 1'b1, 32);

    // false start: 4-clk low pulse
    drive(0, 1'b0, 4);
    rx0 = 1'b1;
    repeat (2) @(negedge clk);
    chk("false_start_busy_hi", 32'(busy0), 32'h1);
    repeat (14) @(negedge clk);
    chk("false_start_busy_lo", 32'(busy0), 32'h0);
    drive(0, 1'b1, 16);

    // 1-clk glitch at the centre of data bit 3 of 0xFF
    push0(9'h0FF, 1'b0, 1'b0, 1'b0);
    send(0, 8, 16, 9'h0FF, 2, 1'b0, 1, 1'b1, 3);
    drive(0, 1'b1, 32);

    // second configuration: back-to-back frames
    push1(9'h055, 1'b0, 1'b0);
    push1(9'h02A, 1'b0, 1'b0);
    send(1, 7, 8, 9'h055, 1, 1'b0, 2, 1'b1, -1);
    send(1, 7, 8, 9'h02A, 1, 1'b0, 2, 1'b1, -1);
    drive(1, 1'b1, 16);
    chk("b2b_dataout1_hold", 32'(dout1), 32'h2A);

    // reset during DATA of a third frame
    drive(1, 1'b0, 8);
    drive(1, 1'b1, 8);
    drive(1, 1'b0, 8);
    drive(1, 1'b1, 4);
    chk("pre_reset_busy1", 32'(busy1), 32'h1);
    rst_n1 = 1'b0;
    @(negedge clk);
    chk("mid_reset_dataout1",    32'(dout1), 32'h0);
    chk("mid_reset_dataerror1",  32'(derr1), 32'h0);
    chk("mid_reset_frameerror1", 32'(ferr1), 32'h0);
    chk("mid_reset_busy1",       32'(busy1), 32'h0);
    rx1 = 1'b1;
    repeat (2) @(negedge clk);
    rst_n1 = 1'b1;
    drive(1, 1'b1, 100);

    // break: line low for three frame times
`ifdef UART_RX_BREAK_DET_EN
    push0(9'h0FF, 1'b0, 1'b0, 1'b1);
`else
    push0(9'h000, 1'b0, 1'b1, 1'b0);
`endif
    drive(0, 1'b0, 3 * 11 * 16);
    drive(0, 1'b1, 24);
    push0(9'h05A, 1'b0, 1'b0, 1'b0);
    send(0, 8, 16, 9'h05A, 2, 1'b0, 1, 1'b1, -1);
    drive(0, 1'b1, 32);

    repeat (50) @(negedge clk);
    chk("ch0_queue_drained", 32'(q0.size()), 32'h0);
    chk("ch1_queue_drained", 32'(q1.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
